vape_exec_flag: RTL and testbench
=================================

Name: vape_exec_flag

Overview:
- Downstream consumer of the VAPE atomicity monitor's combinational exec output.
- Adds memory-write, interrupt and DMA checks and keeps the registered, sticky EXEC flag that attestation reports.
- EXEC = 1 only when the executable region (ER) ran start-to-end with no violation and no later tampering.
- Also records the first violation cause and pulses on clean ER completion.

Parameters:
- SMEM_BASE, 16'hA000, base of secure memory; writes here by any master are a violation while armed.
- SMEM_SIZE, 16'h4000, size of secure memory window.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  input  16  current CPU program counter.
- ER_min  input  16  first ER instruction address.
- ER_max  input  16  last ER instruction address.
- OR_min  input  16  output region low bound (inclusive).
- OR_max  input  16  output region high bound (inclusive).
- atom_exec  input  1  exec from the atomicity monitor; 0 = control-flow violation.
- irq  input  1  CPU interrupt taken this cycle.
- data_wr  input  1  CPU data write strobe.
- data_addr  input  16  CPU data write address.
- dma_en  input  1  DMA access active this cycle.
- dma_addr  input  16  DMA access address.
- exec  output  1  registered sticky EXEC flag.
- er_done  output  1  one-cycle pulse on clean ER exit.
- viol_code  output  3  first violation cause since last ER entry.

Behaviour:
- Reset: state=IDLE, exec=0, er_done=0, viol_code=0, latched bounds=0.
- Address predicates use inclusive compares on 16-bit unsigned values:
  - in_er: ER_min <= addr <= ER_max.
  - in_or: OR_min <= addr <= OR_max.
- States:
  - IDLE: exec=0. pc==ER_min -> RUN. Otherwise stay.
  - RUN: exec=0. First violation -> FAIL. pc==ER_max followed by pc outside ER, with no violation -> DONE, er_done=1 for exactly that cycle.
  - DONE: exec=1. Any violation -> FAIL. pc==ER_min -> RUN (re-execution).
  - FAIL: exec=0. pc==ER_min -> RUN.
- Entry into RUN (from any state):
  - viol_code cleared to 0.
  - ER_min/ER_max/OR_min/OR_max captured into shadow registers.
- Violation sources, evaluated in RUN and DONE. viol_code takes the lowest-numbered active source in the cycle:
  - 1: atom_exec==0.
  - 2: irq==1 while pc in_er (RUN only).
  - 3: data_wr to an in_er address.
  - 4: data_wr to in_or while pc outside ER.
  - 5: live ER/OR bounds differ from shadow copy.
  - 6: dma_en with dma_addr in_er or in_or.
  - 7: any write, CPU or DMA, into [SMEM_BASE, SMEM_BASE+SMEM_SIZE-1].
- viol_code is sticky: once non-zero it holds until the next RUN entry.
- Timing: exec, er_done and viol_code are registered. The response appears one cycle after the causing input.
- A violation and pc==ER_min in the same cycle: RUN entry wins; viol_code=0.
- Invalid bounds (ER_min >= ER_max, or OR_min > OR_max):
  - Forces FAIL with code 5 from any state except IDLE.
  - In IDLE, RUN entry is blocked.
- rst_n assertion mid-RUN or mid-DONE: immediate return to the reset values. EXEC never survives reset.

Optional Feature:
- Macro: VAPE_DMA_CHECK_EN.
- Defined: source 6 is active, and DMA writes count toward source 7.
- Undefined: dma_en and dma_addr are ignored, code 6 is never produced, and source 7 checks CPU writes only. The ports remain present.

Test Plan:
- ER 16'hE000-16'hE0FE, OR 16'h0200-16'h02FF:
  - Stimulus: pc sequence E000, E002..E0FE, then 16'h4000, atom_exec=1 throughout.
  - Response: er_done pulses one cycle after pc=4000; exec=1 thereafter; viol_code=0.
- After DONE, data_wr=1 to 16'h0210 with pc=16'h4010 -> exec falls to 0 the next cycle; viol_code=4.
- Mid-RUN at pc=E050:
  - Stimulus: irq=1 and atom_exec=0 in the same cycle.
  - Response: FAIL; viol_code=1, since priority favours the lower code; exec stays 0.
- In DONE, ER_max changed to 16'hE100 -> viol_code=5, exec=0. Then pc=E000 -> RUN, viol_code cleared to 0.
- Macro on:
  - DMA to 16'hE010 during RUN -> FAIL, code 6.
  - With macro off, the same stimulus completes -> exec=1.
- rst_n pulled low for 1 cycle while in DONE -> exec=0, viol_code=0, state IDLE immediately; pc outside ER keeps exec=0.

Source files
------------

// File: rtl/vape_exec_flag_if.sv
// Signal bundle between the CPU/atomicity-monitor side and the VAPE EXEC flag block.
// The master drives the observed CPU/DMA activity; the slave returns the attestation flags.
interface vape_exec_flag_if;
  logic [15:0] pc;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic [15:0] OR_min;
  logic [15:0] OR_max;
  logic        atom_exec;
  logic        irq;
  logic        data_wr;
  logic [15:0] data_addr;
  logic        dma_en;
  logic [15:0] dma_addr;
  logic        exec;
  logic        er_done;
  logic [2:0]  viol_code;

  modport master (
    output pc, ER_min, ER_max, OR_min, OR_max, atom_exec, irq,
           data_wr, data_addr, dma_en, dma_addr,
    input  exec, er_done, viol_code
  );

  modport slave (
    input  pc, ER_min, ER_max, OR_min, OR_max, atom_exec, irq,
           data_wr, data_addr, dma_en, dma_addr,
    output exec, er_done, viol_code
  );
endinterface

// File: rtl/vape_exec_flag.sv
// Sticky EXEC flag for VAPE attestation: tracks one ER execution and latches the first violation.
// Define VAPE_DMA_CHECK_EN to include DMA accesses in the ER/OR and secure-memory checks.
module vape_exec_flag #(
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  vape_exec_flag_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_e;

  state_e      state_q, state_d;
  logic        exec_q, exec_d;
  logic        er_done_q, er_done_d;
  logic [2:0]  viol_code_q, viol_code_d;
  logic        at_max_q, at_max_d;
  logic [15:0] sh_er_min_q, sh_er_min_d;
  logic [15:0] sh_er_max_q, sh_er_max_d;
  logic [15:0] sh_or_min_q, sh_or_min_d;
  logic [15:0] sh_or_max_q, sh_or_max_d;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Widened to 17 bits so a window ending at 16'hFFFF does not wrap.
  function automatic logic in_smem(input logic [15:0] addr);
    logic [16:0] a, lo, hi_excl;
    a       = {1'b0, addr};
    lo      = {1'b0, SMEM_BASE};
    hi_excl = lo + {1'b0, SMEM_SIZE};
    return (a >= lo) && (a < hi_excl);
  endfunction

  logic       bounds_ok;
  logic       entry_req;
  logic       shadow_mismatch;
  logic       pc_in_er;
  logic [7:1] src;
  logic       viol_any;
  logic [2:0] viol_enc;
  logic       dma_er_or;
  logic       dma_smem;

  always_comb begin
    bounds_ok       = (bus.ER_min < bus.ER_max) && (bus.OR_min <= bus.OR_max);
    entry_req       = (bus.pc == bus.ER_min) && bounds_ok;
    shadow_mismatch = (bus.ER_min != sh_er_min_q) || (bus.ER_max != sh_er_max_q) ||
                      (bus.OR_min != sh_or_min_q) || (bus.OR_max != sh_or_max_q);
    pc_in_er        = in_range(bus.pc, sh_er_min_q, sh_er_max_q);
  end

`ifdef VAPE_DMA_CHECK_EN
  always_comb begin
    dma_er_or = bus.dma_en && (in_range(bus.dma_addr, sh_er_min_q, sh_er_max_q) ||
                               in_range(bus.dma_addr, sh_or_min_q, sh_or_max_q));
    dma_smem  = bus.dma_en && in_smem(bus.dma_addr);
  end
`else
  logic unused_dma;
  assign unused_dma = ^{bus.dma_en, bus.dma_addr};
  assign dma_er_or  = 1'b0;
  assign dma_smem   = 1'b0;
`endif

  // Predicates use the shadow bounds: those are the values attestation vouches for.
  always_comb begin
    src[1] = !bus.atom_exec;
    src[2] = bus.irq && pc_in_er && (state_q == RUN);
    src[3] = bus.data_wr && in_range(bus.data_addr, sh_er_min_q, sh_er_max_q);
    src[4] = bus.data_wr && in_range(bus.data_addr, sh_or_min_q, sh_or_max_q) && !pc_in_er;
    src[5] = shadow_mismatch || !bounds_ok;
    src[6] = dma_er_or;
    src[7] = (bus.data_wr && in_smem(bus.data_addr)) || dma_smem;
    viol_any = |src;
  end

  always_comb begin
    viol_enc = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (src[i]) viol_enc = 3'(i);
    end
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    viol_code_d = viol_code_q;
    er_done_d   = 1'b0;
    at_max_d    = 1'b0;
    sh_er_min_d = sh_er_min_q;
    sh_er_max_d = sh_er_max_q;
    sh_or_min_d = sh_or_min_q;
    sh_or_max_d = sh_or_max_q;

    unique case (state_q)
      IDLE: begin
        if (entry_req) state_d = RUN;
      end
      RUN: begin
        if (viol_any) begin
          state_d = FAIL;
        end else if (at_max_q && !pc_in_er) begin
          state_d   = DONE;
          er_done_d = 1'b1;
        end else begin
          at_max_d = (bus.pc == sh_er_max_q);
        end
      end
      DONE: begin
        // Re-execution takes precedence over a violation seen in the same cycle.
        if (entry_req)     state_d = RUN;
        else if (viol_any) state_d = FAIL;
      end
      FAIL: begin
        if (entry_req) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == FAIL && viol_code_q == 3'd0) viol_code_d = viol_enc;

    if (state_d == RUN && state_q != RUN) begin
      viol_code_d = 3'd0;
      sh_er_min_d = bus.ER_min;
      sh_er_max_d = bus.ER_max;
      sh_or_min_d = bus.OR_min;
      sh_or_max_d = bus.OR_max;
    end

    exec_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exec_q      <= 1'b0;
      er_done_q   <= 1'b0;
      viol_code_q <= 3'd0;
      at_max_q    <= 1'b0;
      sh_er_min_q <= 16'h0000;
      sh_er_max_q <= 16'h0000;
      sh_or_min_q <= 16'h0000;
      sh_or_max_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      exec_q      <= exec_d;
      er_done_q   <= er_done_d;
      viol_code_q <= viol_code_d;
      at_max_q    <= at_max_d;
      sh_er_min_q <= sh_er_min_d;
      sh_er_max_q <= sh_er_max_d;
      sh_or_min_q <= sh_or_min_d;
      sh_or_max_q <= sh_or_max_d;
    end
  end

  assign bus.exec      = exec_q;
  assign bus.er_done   = er_done_q;
  assign bus.viol_code = viol_code_q;

endmodule

// File: tb/tb_vape_exec_flag.sv
// Scoreboard bench for vape_exec_flag: each driven cycle queues its expected outputs,
// which are popped and compared one clock later. DMA expectations follow VAPE_DMA_CHECK_EN.
module tb_vape_exec_flag;

  logic clk;
  logic rst_n;
  vape_exec_flag_if bus ();

  vape_exec_flag dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef VAPE_DMA_CHECK_EN
  localparam bit DMA_ON = 1'b1;
`else
  localparam bit DMA_ON = 1'b0;
`endif

  typedef struct packed {
    logic       exec;
    logic       er_done;
    logic [2:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected response, then score it after the edge.
  task automatic cyc(input logic [15:0] p, input logic ex, input logic dn, input logic [2:0] code);
    exp_t e;
    bus.pc = p;
    exp_q.push_back('{exec: ex, er_done: dn, code: code});
    @(posedge clk);
    #1;
    bus.irq     = 1'b0;
    bus.data_wr = 1'b0;
    bus.dma_en  = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("exec@%h", p),      {7'd0, bus.exec},      {7'd0, e.exec});
      check($sformatf("er_done@%h", p),   {7'd0, bus.er_done},   {7'd0, e.er_done});
      check($sformatf("viol_code@%h", p), {5'd0, bus.viol_code}, {5'd0, e.code});
    end
  endtask

  task automatic clean_run();
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    for (int a = 16'hE002; a <= 16'hE0FE; a += 2) cyc(a[15:0], 1'b0, 1'b0, 3'd0);
    cyc(16'h4000, 1'b1, 1'b1, 3'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pc        = 16'h0000;
    bus.ER_min    = 16'hE000;
    bus.ER_max    = 16'hE0FE;
    bus.OR_min    = 16'h0200;
    bus.OR_max    = 16'h02FF;
    bus.atom_exec = 1'b1;
    bus.irq       = 1'b0;
    bus.data_wr   = 1'b0;
    bus.data_addr = 16'h0000;
    bus.dma_en    = 1'b0;
    bus.dma_addr  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_exec", {7'd0, bus.exec}, 8'd0);
    check("reset_er_done", {7'd0, bus.er_done}, 8'd0);
    check("reset_viol_code", {5'd0, bus.viol_code}, 8'd0);
    rst_n = 1'b1;

    // Idle outside ER, then a clean ER pass.
    cyc(16'h4000, 1'b0, 1'b0, 3'd0);
    clean_run();
    cyc(16'h4002, 1'b1, 1'b0, 3'd0);

    // OR write from outside ER after completion.
    bus.data_wr = 1'b1; bus.data_addr = 16'h0210;
    cyc(16'h4010, 1'b0, 1'b0, 3'd4);
    cyc(16'h4012, 1'b0, 1'b0, 3'd4);

    // irq and atom_exec=0 together mid-RUN: lower code wins.
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    for (int a = 16'hE002; a <= 16'hE04E; a += 2) cyc(a[15:0], 1'b0, 1'b0, 3'd0);
    bus.irq = 1'b1; bus.atom_exec = 1'b0;
    cyc(16'hE050, 1'b0, 1'b0, 3'd1);
    bus.atom_exec = 1'b1;
    cyc(16'hE052, 1'b0, 1'b0, 3'd1);

    // Bound tampering in DONE, re-entry clears, tampering in RUN.
    clean_run();
    bus.ER_max = 16'hE100;
    cyc(16'h4000, 1'b0, 1'b0, 3'd5);
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    cyc(16'hE002, 1'b0, 1'b0, 3'd0);
    bus.ER_max = 16'hE0FE;
    cyc(16'hE004, 1'b0, 1'b0, 3'd5);

    // DMA into ER during RUN.
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    bus.dma_en = 1'b1; bus.dma_addr = 16'hE010;
    cyc(16'hE002, 1'b0, 1'b0, DMA_ON ? 3'd6 : 3'd0);
    for (int a = 16'hE004; a <= 16'hE0FE; a += 2) cyc(a[15:0], 1'b0, 1'b0, DMA_ON ? 3'd6 : 3'd0);
    cyc(16'h4000, !DMA_ON, !DMA_ON, DMA_ON ? 3'd6 : 3'd0);

    // Secure memory boundaries, then re-entry beating a same-cycle violation.
    clean_run();
    bus.data_wr = 1'b1; bus.data_addr = 16'h9FFF;
    cyc(16'h4002, 1'b1, 1'b0, 3'd0);
    bus.data_wr = 1'b1; bus.data_addr = 16'hDFFF;
    cyc(16'h4004, 1'b0, 1'b0, 3'd7);
    clean_run();
    bus.data_wr = 1'b1; bus.data_addr = 16'hE010; bus.atom_exec = 1'b0;
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    bus.atom_exec = 1'b1;
    cyc(16'hE002, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset while in DONE.
    cyc(16'hE004, 1'b0, 1'b0, 3'd0);
    for (int a = 16'hE006; a <= 16'hE0FE; a += 2) cyc(a[15:0], 1'b0, 1'b0, 3'd0);
    cyc(16'h4000, 1'b1, 1'b1, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_exec", {7'd0, bus.exec}, 8'd0);
    check("async_rst_viol_code", {5'd0, bus.viol_code}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(16'h4000, 1'b0, 1'b0, 3'd0);

    // Invalid bounds: entry blocked in IDLE, forced FAIL in RUN.
    bus.ER_min = 16'hE0FE; bus.ER_max = 16'hE000;
    cyc(16'hE0FE, 1'b0, 1'b0, 3'd0);
    cyc(16'hE0FE, 1'b0, 1'b0, 3'd0);
    bus.ER_min = 16'hE000; bus.ER_max = 16'hE0FE;
    cyc(16'hE000, 1'b0, 1'b0, 3'd0);
    cyc(16'hE002, 1'b0, 1'b0, 3'd0);
    bus.OR_min = 16'h0300;
    cyc(16'hE004, 1'b0, 1'b0, 3'd5);
    cyc(16'hE000, 1'b0, 1'b0, 3'd5);
    bus.OR_min = 16'h0200;

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
